// File: rtl/circ_fifo_pkg.sv
// circ_fifo_pkg: width helpers and read-mode constants shared by the circular FIFO.
//   clog2       ceiling log2 of a positive integer (clog2(1) = 0)
//   calc_ptr_w  pointer width PTR_W for a given depth
//   calc_cnt_w  occupancy width CNT_W, wide enough to hold the value DEPTH itself
package circ_fifo_pkg;

    localparam int RD_REGISTERED = 0;
    localparam int RD_SHOW_AHEAD = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int calc_ptr_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/circ_ptr.sv
// circ_ptr: modulo-DEPTH pointer register with enable and synchronous clear.
//   clk    rising-edge clock
//   rst    asynchronous active-low reset, clears the pointer
//   clr_i  synchronous clear, wins over en_i
//   en_i   advance the pointer by one, DEPTH-1 wraps to 0
//   ptr_o  current pointer value
module circ_ptr #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Explicit compare against DEPTH-1 so non-power-of-two depths wrap correctly.
    always_comb
        ptr_d = clr_i ? '0 :
                !en_i ? ptr_q :
                (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;

    assign ptr_o = ptr_q;

endmodule

// File: rtl/circ_fifo.sv
// circ_fifo: single-clock circular FIFO of arbitrary depth with occupancy flags,
// registered or show-ahead read, synchronous flush and overflow/underflow pulses.
//   clk, rst                 clock, asynchronous active-low reset
//   wr, data_in              write request and data
//   rd                       read/pop request
//   flush                    synchronous clear of contents, beats rd and wr
//   data_out, data_valid     read data and its qualifier
//   full, empty              count == DEPTH, count == 0
//   almost_full/empty        count >= AF_TH, count <= AE_TH
//   count                    occupancy
//   overflow, underflow      one-cycle pulses for a rejected write/read
module circ_fifo
    import circ_fifo_pkg::*;
#(
    parameter  int WORD_SZ    = 32,
    parameter  int DEPTH      = 4,
    parameter  int AF_TH      = DEPTH - 1,
    parameter  int AE_TH      = 1,
    parameter  int SHOW_AHEAD = RD_REGISTERED,
    localparam int PTR_W      = calc_ptr_w(DEPTH),
    localparam int CNT_W      = calc_cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [WORD_SZ-1:0] data_in,
    input  logic               rd,
    input  logic               flush,
    output logic [WORD_SZ-1:0] data_out,
    output logic               data_valid,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic               underflow
);

    logic [WORD_SZ-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WORD_SZ-1:0] dout_q, dout_d;
    logic               dv_q, dv_d, ovf_q, ovf_d, udf_q, udf_d;
    logic               rd_ok, wr_ok, rd_en, wr_en;

    assign full         = count_q == CNT_W'(DEPTH);
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= CNT_W'(AF_TH);
    assign almost_empty = count_q <= CNT_W'(AE_TH);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Show-ahead drives zero while empty so data_out stays at its reset value
    // until a word actually exists.
    assign data_out   = (SHOW_AHEAD == RD_SHOW_AHEAD) ? (empty ? '0 : mem_q[rd_ptr]) : dout_q;
    assign data_valid = (SHOW_AHEAD == RD_SHOW_AHEAD) ? ~empty : dv_q;

    always_comb begin
        rd_ok   = rd & ~empty;
        // A write into a full FIFO still fits when the same edge pops a word.
        wr_ok   = wr & (~full | rd_ok);
        rd_en   = rd_ok & ~flush;
        wr_en   = wr_ok & ~flush;
        count_d = flush ? '0 :
                  (wr_en & ~rd_en) ? count_q + CNT_W'(1) :
                  (rd_en & ~wr_en) ? count_q - CNT_W'(1) : count_q;
        dout_d  = rd_en ? mem_q[rd_ptr] : dout_q;
        dv_d    = rd_en;
        ovf_d   = ~flush & wr & ~wr_ok;
        udf_d   = ~flush & rd & empty;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end

    // Storage has no reset; stale words are never exposed since count gates reads.
    always_ff @(posedge clk)
        if (wr_en) mem_q[wr_ptr] <= data_in;

    circ_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (rd_en),
        .ptr_o (rd_ptr)
    );

    circ_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (wr_en),
        .ptr_o (wr_ptr)
    );

endmodule

// File: tb/tb_circ_fifo.sv
// tb_circ_fifo: checks a registered DEPTH=4 FIFO and a show-ahead DEPTH=3 FIFO
// driven by the same stimulus against queue-based reference models.
module tb_circ_fifo;

    logic       clk = 1'b0;
    logic       rst, wr, rd, flush;
    logic [7:0] din;

    logic [7:0] a_dout, b_dout;
    logic       a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic       b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] a_count;
    logic [1:0] b_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] qa[$], qb[$];
    logic [7:0] ma_dout;
    logic       ma_dv, ma_ovf, ma_udf, mb_ovf, mb_udf;

    always #5 clk = ~clk;

    circ_fifo #(.WORD_SZ(8), .DEPTH(4), .SHOW_AHEAD(0)) dut_a (
        .clk(clk), .rst(rst), .wr(wr), .data_in(din), .rd(rd), .flush(flush),
        .data_out(a_dout), .data_valid(a_dv), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf)
    );

    circ_fifo #(.WORD_SZ(8), .DEPTH(3), .AF_TH(2), .AE_TH(0), .SHOW_AHEAD(1)) dut_b (
        .clk(clk), .rst(rst), .wr(wr), .data_in(din), .rd(rd), .flush(flush),
        .data_out(b_dout), .data_valid(b_dv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf)
    );

    typedef struct {
        logic       wr, rd, fl;
        logic [7:0] din;
        int         cnt;
        logic       full, empty, dv;
        logic [7:0] dout;
        logic       ovf, udf;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        ma_dout = 8'h00;
        ma_dv = 0; ma_ovf = 0; ma_udf = 0; mb_ovf = 0; mb_udf = 0;
    endtask

    task automatic model_edge();
        bit rok, wok;
        if (flush) begin
            qa.delete();
            qb.delete();
            ma_dv = 0; ma_ovf = 0; ma_udf = 0; mb_ovf = 0; mb_udf = 0;
        end else begin
            rok = rd && qa.size() > 0;
            wok = wr && (qa.size() < 4 || rok);
            ma_ovf = wr && !wok;
            ma_udf = rd && qa.size() == 0;
            ma_dv  = rok;
            if (rok) ma_dout = qa.pop_front();
            if (wok) qa.push_back(din);
            rok = rd && qb.size() > 0;
            wok = wr && (qb.size() < 3 || rok);
            mb_ovf = wr && !wok;
            mb_udf = rd && qb.size() == 0;
            if (rok) void'(qb.pop_front());
            if (wok) qb.push_back(din);
        end
    endtask

    task automatic check_all();
        chk("a_count", 32'(a_count), qa.size());
        chk("a_full",  32'(a_full),  32'(qa.size() == 4));
        chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
        chk("a_afull", 32'(a_af),    32'(qa.size() >= 3));
        chk("a_aempty",32'(a_ae),    32'(qa.size() <= 1));
        chk("a_dv",    32'(a_dv),    32'(ma_dv));
        chk("a_dout",  32'(a_dout),  32'(ma_dout));
        chk("a_ovf",   32'(a_ovf),   32'(ma_ovf));
        chk("a_udf",   32'(a_udf),   32'(ma_udf));
        chk("b_count", 32'(b_count), qb.size());
        chk("b_full",  32'(b_full),  32'(qb.size() == 3));
        chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
        chk("b_afull", 32'(b_af),    32'(qb.size() >= 2));
        chk("b_aempty",32'(b_ae),    32'(qb.size() == 0));
        chk("b_dv",    32'(b_dv),    32'(qb.size() > 0));
        if (qb.size() > 0) chk("b_dout", 32'(b_dout), 32'(qb[0]));
        chk("b_ovf",   32'(b_ovf),   32'(mb_ovf));
        chk("b_udf",   32'(b_udf),   32'(mb_udf));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic w, input logic r, input logic f, input logic [7:0] d);
        wr = w; rd = r; flush = f; din = d;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 8'h00);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 8'h00);
        //            wr rd fl din     cnt f e dv dout   ov un
        tbl[0]  = '{1, 0, 0, 8'h11, 1, 0, 0, 0, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 0, 8'h22, 2, 0, 0, 0, 8'h00, 0, 0};
        tbl[2]  = '{1, 0, 0, 8'h33, 3, 0, 0, 0, 8'h00, 0, 0};
        tbl[3]  = '{1, 0, 0, 8'h44, 4, 1, 0, 0, 8'h00, 0, 0};
        tbl[4]  = '{1, 0, 0, 8'h55, 4, 1, 0, 0, 8'h00, 1, 0};
        tbl[5]  = '{0, 1, 0, 8'h00, 3, 0, 0, 1, 8'h11, 0, 0};
        tbl[6]  = '{0, 1, 0, 8'h00, 2, 0, 0, 1, 8'h22, 0, 0};
        tbl[7]  = '{0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h33, 0, 0};
        tbl[8]  = '{0, 1, 0, 8'h00, 0, 0, 1, 1, 8'h44, 0, 0};
        tbl[9]  = '{0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h44, 0, 1};
        tbl[10] = '{1, 1, 0, 8'hAA, 1, 0, 0, 0, 8'h44, 0, 1};
        tbl[11] = '{0, 1, 0, 8'h00, 0, 0, 1, 1, 8'hAA, 0, 0};
        tbl[12] = '{1, 0, 0, 8'h01, 1, 0, 0, 0, 8'hAA, 0, 0};
        tbl[13] = '{1, 0, 0, 8'h02, 2, 0, 0, 0, 8'hAA, 0, 0};
        tbl[14] = '{1, 0, 0, 8'h03, 3, 0, 0, 0, 8'hAA, 0, 0};
        tbl[15] = '{1, 0, 0, 8'h04, 4, 1, 0, 0, 8'hAA, 0, 0};
        tbl[16] = '{1, 1, 0, 8'h05, 4, 1, 0, 1, 8'h01, 0, 0};
        tbl[17] = '{1, 1, 0, 8'h06, 4, 1, 0, 1, 8'h02, 0, 0};
        tbl[18] = '{1, 1, 0, 8'h07, 4, 1, 0, 1, 8'h03, 0, 0};
        tbl[19] = '{1, 0, 0, 8'h08, 4, 1, 0, 0, 8'h03, 1, 0};
        tbl[20] = '{0, 1, 0, 8'h00, 3, 0, 0, 1, 8'h04, 0, 0};
        tbl[21] = '{0, 1, 0, 8'h00, 2, 0, 0, 1, 8'h05, 0, 0};
        tbl[22] = '{0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h06, 0, 0};
        tbl[23] = '{0, 1, 0, 8'h00, 0, 0, 1, 1, 8'h07, 0, 0};
        tbl[24] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h07, 0, 0};

        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].din);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(a_count), tbl[i].cnt);
            chk($sformatf("vec%0d_full", i),  32'(a_full),  32'(tbl[i].full));
            chk($sformatf("vec%0d_empty", i), 32'(a_empty), 32'(tbl[i].empty));
            chk($sformatf("vec%0d_dv", i),    32'(a_dv),    32'(tbl[i].dv));
            chk($sformatf("vec%0d_dout", i),  32'(a_dout),  32'(tbl[i].dout));
            chk($sformatf("vec%0d_ovf", i),   32'(a_ovf),   32'(tbl[i].ovf));
            chk($sformatf("vec%0d_udf", i),   32'(a_udf),   32'(tbl[i].udf));
        end

        // Show-ahead: head word visible one cycle after the write, no rd needed.
        do_reset();
        drive(1, 0, 0, 8'h5A); tick();
        drive(0, 0, 0, 8'h00);
        chk("sa_dout", 32'(b_dout), 32'h5A);
        chk("sa_dv",   32'(b_dv),   32'd1);
        drive(1, 0, 0, 8'h6B); tick();
        chk("sa_afull", 32'(b_af), 32'd1);
        drive(0, 1, 0, 8'h00); tick();
        chk("sa_pop1", 32'(b_dout), 32'h6B);
        tick();
        chk("sa_aempty", 32'(b_ae), 32'd1);
        chk("sa_dv_end", 32'(b_dv), 32'd0);

        // Flush together with a write: nothing stored, no pulses.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 8'(8'hC0 + i)); tick();
        end
        drive(1, 0, 1, 8'hEE); tick();
        chk("fl_count", 32'(a_count), 32'd0);
        chk("fl_empty", 32'(b_empty), 32'd1);
        chk("fl_dv",    32'(a_dv),    32'd0);
        drive(0, 1, 0, 8'h00); tick();
        chk("fl_udf",   32'(a_udf),   32'd1);

        // Asynchronous reset in the middle of a write burst.
        drive(1, 0, 0, 8'h71); tick();
        drive(1, 0, 0, 8'h72); tick();
        drive(0, 1, 0, 8'h00); tick();
        drive(1, 1, 0, 8'h73);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("ar_adout", 32'(a_dout), 32'd0);
        chk("ar_bdout", 32'(b_dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 8'h74); tick();
        chk("ar_first", 32'(a_count), 32'd1);

        // Randomised traffic against the queue models.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                  $urandom_range(0, 39) == 0, 8'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
